// File: rtl/pixel_sink.sv
// Serial pixel receiver: deserialises Q10.6 coordinates and colour, clips them, and
// queues accepted pixels in a 4-entry FIFO feeding a handshaked framebuffer port.
module pixel_sink #(
  parameter int XRES       = 320,
  parameter int YRES       = 240,
  parameter bit ALPHA_TEST = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        VALID,
  input  logic        PX,
  input  logic        PY,
  input  logic        C,
  input  logic        DONE,
  input  logic        FB_READY,
  output logic        FB_WE,
  output logic [16:0] FB_ADDR,
  output logic [15:0] FB_DATA,
  output logic        TRI_DONE,
  output logic        OVERFLOW,
  output logic        PROTO_ERR,
  output logic [15:0] CLIP_CNT
);

  localparam logic [16:0] XRES_W = 17'(XRES);
  localparam logic [16:0] YRES_W = 17'(YRES);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [14:0] sx_q, sx_d;
  logic [14:0] sy_q, sy_d;
  logic [14:0] sc_q, sc_d;

  logic        word_done;
  logic        proto_set;

  logic [9:0]  x_int;
  logic [9:0]  y_int;
  logic [16:0] x_ext;
  logic [16:0] y_ext;
  logic [15:0] colour;
  logic        x_bad;
  logic        y_bad;
  logic        alpha_bad;
  logic        accept;
  logic        clip_evt;
  logic [16:0] addr;

  logic [32:0] mem_q [4];
  logic [32:0] mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        ovf_set;

  logic        ovf_q, ovf_d;
  logic        proto_q, proto_d;
  logic [15:0] clip_q, clip_d;
  logic        pend_q, pend_d;
  logic        tri_fire;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (VALID) state_d = SHIFT;
      SHIFT:   if (!VALID && cnt_q == 4'd15) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The last bit arrives in the completion cycle, so only 15 bits per lane are held.
  always_comb begin
    cnt_d     = cnt_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    sc_d      = sc_q;
    word_done = 1'b0;
    proto_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (VALID) cnt_d = 4'd0;
      end
      SHIFT: begin
        if (VALID) begin
          proto_set = 1'b1;
          cnt_d     = 4'd0;
        end else begin
          sx_d      = {sx_q[13:0], PX};
          sy_d      = {sy_q[13:0], PY};
          sc_d      = {sc_q[13:0], C};
          cnt_d     = cnt_q + 4'd1;
          word_done = (cnt_q == 4'd15);
        end
      end
      default: cnt_d = 4'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= 4'd0;
      sx_q  <= '0;
      sy_q  <= '0;
      sc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
      sc_q  <= sc_d;
    end
  end

  always_comb begin
    x_int     = sx_q[14:5];
    y_int     = sy_q[14:5];
    x_ext     = {7'd0, x_int};
    y_ext     = {7'd0, y_int};
    colour    = {sc_q, C};
    x_bad     = x_int[9] | (x_ext >= XRES_W);
    y_bad     = y_int[9] | (y_ext >= YRES_W);
    alpha_bad = ALPHA_TEST & ~colour[0];
    accept    = word_done & ~(x_bad | y_bad | alpha_bad);
    clip_evt  = word_done & (x_bad | y_bad | alpha_bad);
  end

  // Constant multiply by XRES as a sum of shifted y terms; folds to (y<<8)+(y<<6) for 320.
  always_comb begin
    addr = x_ext;
    for (int i = 0; i < 17; i++) begin
      if (XRES_W[i]) addr = addr + (y_ext << i);
    end
  end

  // Fullness is judged before any same-edge pop, so a pop never makes room for a push.
  always_comb begin
    fifo_empty = (count_q == 3'd0);
    fifo_full  = (count_q == 3'd4);
    push       = accept & ~fifo_full;
    ovf_set    = accept & fifo_full;
    pop        = ~fifo_empty & FB_READY;
    mem_d      = mem_q;
    if (push) mem_d[wr_ptr_q] = {addr, colour};
    wr_ptr_d   = wr_ptr_q + {1'b0, push};
    rd_ptr_d   = rd_ptr_q + {1'b0, pop};
    count_d    = count_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    ovf_d    = ovf_q | ovf_set;
    proto_d  = proto_q | proto_set;
    clip_d   = (clip_evt && clip_q != 16'hFFFF) ? clip_q + 16'd1 : clip_q;
    tri_fire = pend_q & (state_q == IDLE) & fifo_empty;
    pend_d   = tri_fire ? 1'b0 : (pend_q | DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_q   <= 1'b0;
      proto_q <= 1'b0;
      clip_q  <= 16'd0;
      pend_q  <= 1'b0;
    end else begin
      ovf_q   <= ovf_d;
      proto_q <= proto_d;
      clip_q  <= clip_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    FB_WE     = ~fifo_empty;
    FB_ADDR   = fifo_empty ? 17'd0 : mem_q[rd_ptr_q][32:16];
    FB_DATA   = fifo_empty ? 16'd0 : mem_q[rd_ptr_q][15:0];
    TRI_DONE  = tri_fire;
    OVERFLOW  = ovf_q;
    PROTO_ERR = proto_q;
    CLIP_CNT  = clip_q;
  end

endmodule

// File: doc/pixel_sink.md
PIXEL_SINK -- requirements
Module: pixel_sink

Interface
REQ-001 Parameter: XRES, default 320, horizontal framebuffer size in pixels.
REQ-002 Parameter: YRES, default 240, vertical framebuffer size in pixels.
REQ-003 Parameter: ALPHA_TEST, default 1, 1 = discard pixels whose colour bit0 is 0.
REQ-004 CLK  in  1  sole clock, rising-edge.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 VALID  in  1  one-cycle pulse marking the start of a serial pixel word.
REQ-007 PX  in  1  serial x coordinate, Q10.6, MSB first.
REQ-008 PY  in  1  serial y coordinate, Q10.6, MSB first.
REQ-009 C  in  1  serial RGB555+A1 colour, MSB first.
REQ-010 DONE  in  1  one-cycle pulse, triangle finished by sender.
REQ-011 FB_READY  in  1  framebuffer accepts the write this cycle.
REQ-012 FB_WE  out  1  framebuffer write request.
REQ-013 FB_ADDR  out  17  linear pixel address, y*XRES+x.
REQ-014 FB_DATA  out  16  colour word to write.
REQ-015 TRI_DONE  out  1  one-cycle pulse, all pixels of the triangle written.
REQ-016 OVERFLOW  out  1  sticky, a pixel was dropped because the FIFO was full.
REQ-017 PROTO_ERR  out  1  sticky, VALID arrived mid-word.
REQ-018 CLIP_CNT  out  16  pixels discarded by bounds or alpha test, saturating.

Function
REQ-019 Deserializer SHALL have states IDLE and SHIFT, with a 4-bit bit counter.
REQ-020 In IDLE, VALID=1 SHALL enter SHIFT with the counter cleared; PX/PY/C during the VALID cycle SHALL be ignored.
REQ-021 In SHIFT, each cycle SHALL shift PX, PY and C into 16-bit registers LSB-ward (first bit ends as bit15) and increment the counter.
REQ-022 On the 16th SHIFT cycle (counter=15) the word SHALL be complete, the block SHALL return to IDLE, and the word SHALL be evaluated on that same edge.
REQ-023 VALID=1 while in SHIFT (bit cycles 1..16) SHALL set PROTO_ERR, abandon the partial word, and restart capture from the new VALID.
REQ-024 Integer coordinates SHALL be x=PX[15:6] and y=PY[15:6], signed; fraction bits are discarded (truncation).
REQ-025 A word SHALL be discarded, incrementing CLIP_CNT (saturating at 0xFFFF), if x<0, y<0, x>=XRES, y>=YRES, or (ALPHA_TEST=1 and C[0]=0).
REQ-026 Address SHALL be y*XRES+x, computed without a general multiplier: for XRES=320, (y<<8)+(y<<6)+x, 17-bit unsigned.
REQ-027 Accepted words SHALL be pushed as {addr, colour} into a 4-entry FIFO on the completion edge.
REQ-028 If the FIFO is full at push time, the word SHALL be dropped, OVERFLOW set and the FIFO left unchanged; a simultaneous pop SHALL NOT free a slot for that push.
REQ-029 FB_WE SHALL be 1 whenever the FIFO is non-empty; FB_ADDR/FB_DATA SHALL show the head entry and hold stable until FB_WE&&FB_READY.
REQ-030 FB_WE&&FB_READY SHALL pop the head on that edge.
REQ-031 Latency: with an empty FIFO and FB_READY=1, FB_WE SHALL rise in the cycle after bit 16, i.e. 17 cycles after the VALID cycle.
REQ-032 A push and a pop on the same edge SHALL both take effect when the FIFO is neither empty nor full.
REQ-033 DONE SHALL set a pending flag; TRI_DONE SHALL pulse for one cycle at the first edge where the flag is set, the deserializer is IDLE and the FIFO is empty, and that pulse SHALL clear the flag.
REQ-034 DONE during SHIFT SHALL let the in-flight word complete and be written before TRI_DONE.
REQ-035 A second DONE while the flag is already set SHALL be merged, producing a single TRI_DONE.
REQ-036 OVERFLOW and PROTO_ERR SHALL clear only on reset.

Reset
REQ-037 RST_N=0 SHALL asynchronously force IDLE, counter=0, FIFO empty, pending flag=0, FB_WE=0, FB_ADDR=0, FB_DATA=0, TRI_DONE=0, OVERFLOW=0, PROTO_ERR=0, CLIP_CNT=0.
REQ-038 Reset asserted mid-word or with a non-empty FIFO SHALL discard all partial and queued pixels; no FB_WE after RST_N rises until a new word completes.
REQ-039 After deassertion, the first VALID SHALL be honoured no earlier than the first rising edge with RST_N=1.

Verification
REQ-040 VALID, then PX=0x0280, PY=0x0140, C=0xF801, FB_READY=1 -> FB_WE high 17 cycles after VALID, FB_ADDR=1610, FB_DATA=0xF801, for one cycle.
REQ-041 Three pixel words: (x=319,y=239,C=0x07C1), (x=320,y=0,C=0xFFFF), (x=5,y=5,C=0x001E) -> only address 76799 written; CLIP_CNT=2.
REQ-042 FB_READY=0, then six back-to-back valid pixels -> 4 queued, OVERFLOW=1 after the 5th; FB_READY=1 -> exactly 4 writes in order with stable ADDR/DATA while stalled.
REQ-043 VALID again 8 cycles into a word -> PROTO_ERR=1, first word never written, second word written normally.
REQ-044 DONE during bit 10 of the last pixel, FB_READY=1 -> pixel written first, then one TRI_DONE pulse in the cycle after the FIFO empties.
REQ-045 RST_N low for 1 cycle with 3 FIFO entries and a word mid-shift -> all outputs at reset values, no FB_WE afterwards without new VALID.
